// File: rtl/hs_npu_pkg.sv
// Shared NPU types: the 32-bit word type, the memory bridge FSM states and
// word-address helpers used by the NPU memory bridge.
package hs_npu_pkg;

  typedef logic [31:0] uword;

  localparam uword WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } mem_bridge_state_e;

  // Clear the byte-offset bits so a line address points at a whole word.
  function automatic uword word_align(input uword addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/hs_npu_mem_bridge_if.sv
// Avalon-MM word bus between the NPU memory bridge (master) and memory (slave).
interface hs_npu_mem_bridge_if;
  import hs_npu_pkg::*;

  uword avm_address_o;
  logic avm_read_o;
  logic avm_write_o;
  uword avm_writedata_o;
  logic avm_waitrequest_i;
  uword avm_readdata_i;
  logic avm_readdatavalid_i;

  modport master (
    output avm_address_o,
    output avm_read_o,
    output avm_write_o,
    output avm_writedata_o,
    input  avm_waitrequest_i,
    input  avm_readdata_i,
    input  avm_readdatavalid_i
  );

  modport slave (
    input  avm_address_o,
    input  avm_read_o,
    input  avm_write_o,
    input  avm_writedata_o,
    output avm_waitrequest_i,
    output avm_readdata_i,
    output avm_readdatavalid_i
  );

endinterface

// File: rtl/hs_npu_mem_bridge.sv
// NPU line-to-word memory bridge. Each NPU line request becomes
// WORDS_PER_LINE sequential Avalon-MM word transfers; read words are
// assembled into a line and a one-cycle completion pulse goes back to the NPU.
// Word i of a line lives at bits [32*i +: 32] and at byte address base+4*i.
// Optional feature: define HS_NPU_MEM_BRIDGE_LINE_CACHE_EN for a one-entry
// read line cache that answers repeated reads without bus traffic.
module hs_npu_mem_bridge
  import hs_npu_pkg::*;
#(
  parameter int SIZE           = 8,
  parameter int WORDS_PER_LINE = SIZE * 8 / 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        npu_read_req_i,
  input  logic                        npu_write_req_i,
  input  uword                        npu_address_i,
  input  logic [32*WORDS_PER_LINE-1:0] npu_wdata_i,
  output logic                        npu_mem_valid_o,
  output logic [32*WORDS_PER_LINE-1:0] npu_rdata_o,
  hs_npu_mem_bridge_if.master         avm
);

  localparam int WPL   = WORDS_PER_LINE;
  localparam int CNT_W = $clog2(WPL + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WPL - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WPL);

  mem_bridge_state_e state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, recv_cnt_q;
  uword              base_q;
  uword [WPL-1:0]    wline_q, rline_q, line_next, rdata_q, hit_line;
  uword              req_addr, word_addr, wr_word;
  logic              cmd_rd, cmd_wr, rd_accept, wr_accept;
  logic              rsp_take, rd_done, cache_hit, hit_take;

  assign req_addr  = word_align(npu_address_i);
  // Modulo-2^32 add: a line starting near the top of memory wraps to 0.
  assign word_addr = base_q + uword'(issue_cnt_q) * WORD_BYTES;
  assign rd_accept = cmd_rd & ~avm.avm_waitrequest_i;
  assign wr_accept = cmd_wr & ~avm.avm_waitrequest_i;
  // Responses outside RD are strays from an abandoned burst and are dropped.
  assign rsp_take  = (state_q == RD) & avm.avm_readdatavalid_i;
  assign rd_done   = rsp_take & (recv_cnt_q == LAST_IDX);
  assign hit_take  = (state_q == IDLE) & ~npu_write_req_i & npu_read_req_i & cache_hit;

  // Pick the outgoing write word and merge the incoming read word into the line.
  always_comb begin
    wr_word   = '0;
    line_next = rline_q;
    for (int i = 0; i < WPL; i++) begin
      if (issue_cnt_q == CNT_W'(i)) wr_word = wline_q[i];
      if (recv_cnt_q == CNT_W'(i)) line_next[i] = avm.avm_readdata_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state and bus command decode; write wins over read in IDLE.
  always_comb begin
    state_d = state_q;
    cmd_rd  = 1'b0;
    cmd_wr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (npu_write_req_i)     state_d = WR;
        else if (npu_read_req_i) state_d = cache_hit ? DONE : RD;
      end
      RD: begin
        cmd_rd = (issue_cnt_q != FULL_CNT);
        if (rd_done) state_d = DONE;
      end
      WR: begin
        cmd_wr = 1'b1;
        if (wr_accept && issue_cnt_q == LAST_IDX) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue and receive counters; cleared while idle so each burst starts at word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else if (state_q == IDLE) begin
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      if (rd_accept || wr_accept) issue_cnt_q <= issue_cnt_q + 1'b1;
      if (rsp_take)               recv_cnt_q  <= recv_cnt_q + 1'b1;
    end
  end

  // Request capture and read-line assembly; only meaningful under the FSM.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      base_q  <= req_addr;
      wline_q <= npu_wdata_i;
    end
    if (rsp_take) rline_q <= line_next;
  end

  // NPU read line: changes only when a read completes (bus or cache).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           rdata_q <= '0;
    else if (rd_done)  rdata_q <= line_next;
    else if (hit_take) rdata_q <= hit_line;
  end

`ifdef HS_NPU_MEM_BRIDGE_LINE_CACHE_EN
  uword           cache_tag_q;
  logic           cache_vld_q;
  uword [WPL-1:0] cache_line_q;

  assign cache_hit = cache_vld_q & (cache_tag_q == req_addr);
  assign hit_line  = cache_line_q;

  // Cache valid: set by a completed bus read, dropped by a write to the tagged line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cache_vld_q <= 1'b0;
    else if (rd_done)
      cache_vld_q <= 1'b1;
    else if (state_q == IDLE && npu_write_req_i && req_addr == cache_tag_q)
      cache_vld_q <= 1'b0;
  end

  // Cache tag and line filled from every completed bus read.
  always_ff @(posedge clk) begin
    if (rd_done) begin
      cache_tag_q  <= base_q;
      cache_line_q <= line_next;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_line  = '0;
`endif

  assign npu_mem_valid_o     = (state_q == DONE);
  assign npu_rdata_o         = rdata_q;
  assign avm.avm_read_o      = cmd_rd;
  assign avm.avm_write_o     = cmd_wr;
  assign avm.avm_address_o   = (state_q == RD || state_q == WR) ? word_addr : '0;
  assign avm.avm_writedata_o = cmd_wr ? wr_word : '0;

endmodule

// File: tb/tb_hs_npu_mem_bridge.sv
// Bench for hs_npu_mem_bridge (SIZE=8, two words per line). A table of line
// transactions is replayed through a simple in-order memory slave with read
// latency 1; hand sequences cover reset behaviour and stray responses.
module tb_hs_npu_mem_bridge;

  typedef logic [31:0] word_t;

  typedef struct {
    string name;
    logic  wr;
    logic  rd;
    word_t addr;
    word_t wd0;
    word_t wd1;
    int    stall;
    word_t rsp0;
    word_t rsp1;
    int    exp_beats;
    word_t exp_a0;
    word_t exp_a1;
    int    exp_vcyc;
    word_t exp_r0;
    word_t exp_r1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        npu_read_req;
  logic        npu_write_req;
  word_t       npu_address;
  logic [63:0] npu_wdata;
  logic        npu_mem_valid;
  logic [63:0] npu_rdata;

  hs_npu_mem_bridge_if avm_if ();

  hs_npu_mem_bridge #(.SIZE(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .npu_read_req_i  (npu_read_req),
    .npu_write_req_i (npu_write_req),
    .npu_address_i   (npu_address),
    .npu_wdata_i     (npu_wdata),
    .npu_mem_valid_o (npu_mem_valid),
    .npu_rdata_o     (npu_rdata),
    .avm             (avm_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_pass;
  int    n_total;
  vec_t  vecs[10];
  word_t b_addr[8];
  word_t b_data[8];
  logic  b_wr[8];
  int    nb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // One NPU line transaction: request in cycle 0, bus slave served each negedge.
  task automatic run_txn(input vec_t v);
    int    rsp_idx;
    int    stall_left;
    int    vcyc;
    int    pulses;
    logic  pend;
    word_t pend_data;
    nb = 0;
    rsp_idx = 0;
    stall_left = v.stall;
    vcyc = -1;
    pulses = 0;
    pend = 1'b0;
    pend_data = '0;
    @(negedge clk);
    npu_write_req = v.wr;
    npu_read_req  = v.rd;
    npu_address   = v.addr;
    npu_wdata     = {v.wd1, v.wd0};
    avm_if.avm_waitrequest_i   = 1'b0;
    avm_if.avm_readdatavalid_i = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      avm_if.avm_readdatavalid_i = pend;
      avm_if.avm_readdata_i      = pend ? pend_data : 32'hDEAD_BEEF;
      pend = 1'b0;
      if (npu_mem_valid) begin
        pulses++;
        if (vcyc < 0) vcyc = cyc;
        npu_read_req  = 1'b0;
        npu_write_req = 1'b0;
      end
      if (avm_if.avm_read_o || avm_if.avm_write_o) begin
        if (stall_left > 0) begin
          avm_if.avm_waitrequest_i = 1'b1;
          stall_left--;
          if (avm_if.avm_write_o) begin
            check({v.name, "_hold_addr"}, avm_if.avm_address_o, v.exp_a0);
            check({v.name, "_hold_data"}, avm_if.avm_writedata_o, v.wd0);
          end
        end else begin
          avm_if.avm_waitrequest_i = 1'b0;
          if (nb < 8) begin
            b_addr[nb] = avm_if.avm_address_o;
            b_data[nb] = avm_if.avm_writedata_o;
            b_wr[nb]   = avm_if.avm_write_o;
          end
          nb++;
          if (avm_if.avm_read_o) begin
            pend = 1'b1;
            pend_data = (rsp_idx == 0) ? v.rsp0 : (rsp_idx == 1) ? v.rsp1 : 32'h0;
            rsp_idx++;
          end
        end
      end else begin
        avm_if.avm_waitrequest_i = 1'b0;
      end
      if (vcyc >= 0 && cyc >= vcyc + 2) break;
    end
    avm_if.avm_waitrequest_i   = 1'b0;
    avm_if.avm_readdatavalid_i = 1'b0;
    check({v.name, "_beats"}, nb, v.exp_beats);
    for (int k = 0; k < v.exp_beats && k < nb && k < 2; k++) begin
      check({v.name, "_addr"}, b_addr[k], (k == 0) ? v.exp_a0 : v.exp_a1);
      check({v.name, "_is_write"}, b_wr[k], v.wr);
      if (v.wr) check({v.name, "_wdata"}, b_data[k], (k == 0) ? v.wd0 : v.wd1);
    end
    check({v.name, "_valid_cycle"}, vcyc, v.exp_vcyc);
    check({v.name, "_pulses"}, pulses, 1);
    check({v.name, "_rdata"}, npu_rdata, {v.exp_r1, v.exp_r0});
  endtask

  initial begin
    vec_t  v_after;
    word_t last_r0;
    word_t last_r1;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    npu_read_req = 1'b0;
    npu_write_req = 1'b0;
    npu_address = '0;
    npu_wdata = '0;
    avm_if.avm_waitrequest_i = 1'b0;
    avm_if.avm_readdata_i = '0;
    avm_if.avm_readdatavalid_i = 1'b0;

    //            name       wr    rd    addr          wd0    wd1    st rsp0   rsp1   nb a0            a1            vc r0     r1
    vecs[0] = '{"rd100",     1'b0, 1'b1, 32'h100,      32'h0, 32'h0, 0, 32'hA, 32'hB, 2, 32'h100,      32'h104,      4, 32'hA,  32'hB};
    vecs[1] = '{"wr200",     1'b1, 1'b0, 32'h200,      32'h11,32'h22,3, 32'h0, 32'h0, 2, 32'h200,      32'h204,      6, 32'hA,  32'hB};
    vecs[2] = '{"both300",   1'b1, 1'b1, 32'h300,      32'h33,32'h44,0, 32'h0, 32'h0, 2, 32'h300,      32'h304,      3, 32'hA,  32'hB};
    vecs[3] = '{"rerd300",   1'b0, 1'b1, 32'h300,      32'h0, 32'h0, 0, 32'h55,32'h66,2, 32'h300,      32'h304,      4, 32'h55, 32'h66};
    vecs[4] = '{"rdwrap",    1'b0, 1'b1, 32'hFFFF_FFFE,32'h0, 32'h0, 0, 32'h77,32'h88,2, 32'hFFFF_FFFC,32'h0,        4, 32'h77, 32'h88};
    vecs[5] = '{"rdstall",   1'b0, 1'b1, 32'h140,      32'h0, 32'h0, 2, 32'h99,32'hAA,2, 32'h140,      32'h144,      6, 32'h99, 32'hAA};
    vecs[6] = '{"rd80",      1'b0, 1'b1, 32'h80,       32'h0, 32'h0, 0, 32'h1, 32'h2, 2, 32'h80,       32'h84,       4, 32'h1,  32'h2};
`ifdef HS_NPU_MEM_BRIDGE_LINE_CACHE_EN
    vecs[7] = '{"rd80again", 1'b0, 1'b1, 32'h83,       32'h0, 32'h0, 0, 32'h3, 32'h4, 0, 32'h0,        32'h0,        1, 32'h1,  32'h2};
    vecs[8] = '{"wr80",      1'b1, 1'b0, 32'h80,       32'h5, 32'h6, 0, 32'h0, 32'h0, 2, 32'h80,       32'h84,       3, 32'h1,  32'h2};
`else
    vecs[7] = '{"rd80again", 1'b0, 1'b1, 32'h83,       32'h0, 32'h0, 0, 32'h3, 32'h4, 2, 32'h80,       32'h84,       4, 32'h3,  32'h4};
    vecs[8] = '{"wr80",      1'b1, 1'b0, 32'h80,       32'h5, 32'h6, 0, 32'h0, 32'h0, 2, 32'h80,       32'h84,       3, 32'h3,  32'h4};
`endif
    vecs[9] = '{"rd80post",  1'b0, 1'b1, 32'h80,       32'h0, 32'h0, 0, 32'h7, 32'h8, 2, 32'h80,       32'h84,       4, 32'h7,  32'h8};
    last_r0 = 32'h7;
    last_r1 = 32'h8;

    // Reset state while rst is held.
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_valid", npu_mem_valid, 0);
    check("rst_rdata", npu_rdata, 0);
    check("rst_read", avm_if.avm_read_o, 0);
    check("rst_write", avm_if.avm_write_o, 0);
    check("rst_address", avm_if.avm_address_o, 0);
    check("rst_writedata", avm_if.avm_writedata_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Stray read responses while idle must not complete anything.
    @(negedge clk);
    avm_if.avm_readdatavalid_i = 1'b1;
    avm_if.avm_readdata_i = 32'h1234_5678;
    @(negedge clk);
    check("stray_valid", npu_mem_valid, 0);
    @(negedge clk);
    avm_if.avm_readdatavalid_i = 1'b0;
    check("stray_valid2", npu_mem_valid, 0);
    check("stray_rdata", npu_rdata, {last_r1, last_r0});

    // Reset in the middle of a read burst after one word has arrived.
    @(negedge clk);
    npu_read_req = 1'b1;
    npu_address = 32'h40;
    @(negedge clk);
    check("midrst_rd0", {avm_if.avm_read_o, avm_if.avm_address_o}, {1'b1, 32'h40});
    @(negedge clk);
    check("midrst_rd1", {avm_if.avm_read_o, avm_if.avm_address_o}, {1'b1, 32'h44});
    avm_if.avm_readdatavalid_i = 1'b1;
    avm_if.avm_readdata_i = 32'hD1;
    @(negedge clk);
    avm_if.avm_readdatavalid_i = 1'b0;
    check("midrst_pre_addr", avm_if.avm_address_o, 32'h48);
    rst = 1'b1;
    npu_read_req = 1'b0;
    #1;
    check("midrst_mem_valid", npu_mem_valid, 0);
    check("midrst_rdata", npu_rdata, 0);
    check("midrst_read", avm_if.avm_read_o, 0);
    check("midrst_address", avm_if.avm_address_o, 0);
    check("midrst_write", avm_if.avm_write_o, 0);
    @(negedge clk);
    rst = 1'b0;

    v_after = '{"rd40", 1'b0, 1'b1, 32'h40, 32'h0, 32'h0, 0, 32'hC1, 32'hC2, 2, 32'h40, 32'h44, 4, 32'hC1, 32'hC2};
    run_txn(v_after);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
